siso_pulse_sequencer: RTL
=========================

# siso_pulse_sequencer

Sequencer for the mux-latch SISO nibble delay line (256 latches, 48 nibbles). Accepts one 4-bit nibble per valid/ready handshake, drives it onto the array input, and emits four non-overlapping positive pulses on `latch[0]`..`latch[3]` in ascending order. Each pulse sequence advances the line by one nibble. The block samples the nibble leaving the array and tracks fill level, so downstream logic sees a plain delayed stream.

## Interface
- `PULSE_W`, 1: cycles each latch pulse stays high (≥1).
- `GAP_W`, 1: low cycles after each pulse, before the next pulse or IDLE (≥1).
- `DEPTH`, 48: nibbles stored in the array, which is the latency in sequences.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  4  nibble to push.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  sequencer accepts a nibble this cycle.
- `out_data`  out  4  nibble that left the array.
- `out_valid`  out  1  one-cycle strobe qualifying `out_data`.
- `siso_in`  out  4  to array data input, registered.
- `siso_out`  in  4  from array data output.
- `latch`  out  4  to array pass/keep controls; positive pulses, registered.
- `fill`  out  $clog2(DEPTH+1)  number of valid nibbles in the array.

## Operation
- **States:** IDLE → SETUP → P0 → G0 → P1 → G1 → P2 → G2 → P3 → G3 → IDLE.
- **IDLE:** `in_ready`=1 (combinational from state). On `in_valid & in_ready`:
  - `siso_in` ← `in_data`.
  - `out_data` ← `siso_out`.
  - `out_valid` is set for the next cycle only if `fill`==DEPTH.
  - Go to SETUP.
- **SETUP:** one cycle, all latches low, so `siso_in` settles before any pulse.
- **Pk:** `latch[k]`=1 for PULSE_W cycles; all other bits are 0.
- **Gk:** all latches 0 for GAP_W cycles.
- **Shared timer:** one down-counter reloads at each Pk/Gk entry and advances the state at zero.
- **Leaving G3:** `fill` ← min(`fill`+1, DEPTH), saturating. `siso_in` holds its value until the next accept.
- **Pulse guarantees:**
  - At most one bit of `latch` is high at any time.
  - Every falling edge is followed by ≥GAP_W low cycles.
- **Handshake:** `in_ready`=0 in every state except IDLE. `in_valid` held high while not ready is not consumed.
- **Reset (async, including mid-sequence):**
  - `latch`=0 immediately, state=IDLE, `fill`=0.
  - `siso_in`=0, `out_data`=0, `out_valid`=0.
  - Array contents are treated as invalid afterwards. Any partially shifted nibble is lost.
- **Simultaneous events:** accept and `fill` saturation in the same sequence are legal. The sampled `out_data` is the oldest nibble before the shift.

## Timing
- Accept-to-accept period: 2 + 4·(PULSE_W+GAP_W) cycles; 10 cycles with defaults.
- `out_valid` rises the cycle after the accepting edge and lasts exactly one cycle.
- Data latency: a nibble accepted as the N-th push appears on `out_data` at push N+DEPTH. With defaults, the output strobe follows the push at index 48 later.
- `latch` goes high the cycle after SETUP. With defaults, `latch[0]` is high in cycle 2 after accept, and `latch[3]` in cycle 8.
- All outputs except `in_ready` come straight from flops, so the array controls are glitch-free.

## Configuration
- **`SISO_SEQ_FLUSH_EN` defined:** adds input `flush` (1 bit).
  - `flush`=1 in IDLE with `fill`>0 starts an internal sequence: `siso_in`←0, no handshake, `in_ready`=0.
  - Each internal sequence produces an `out_valid` strobe and decrements `fill`.
  - Internal sequences repeat until `fill`=0.
  - `flush` has priority over `in_valid` when both are high in IDLE.
- **Undefined:** no `flush` port. `fill` only increments.

## Structure
- Package `siso_seq_pkg` holds:
  - state enum (IDLE, SETUP, P0..G3);
  - localparams for the default PULSE_W, GAP_W and DEPTH;
  - the sequence-length constant.
- One sub-module, `siso_phase_timer`: loadable down-counter with a `done` output, width $clog2(max(PULSE_W,GAP_W)+1).
- The array is instantiated next to this block, not inside it.

## Test plan
- **Reset pulse check:** reset, then push 0x5 with defaults → `latch` shows 1,2,4,8 one-hot in cycles 2,4,6,8 after accept; zero elsewhere; `in_ready` low for 9 cycles.
- **Fill and latency:** with a behavioural array model, push 0x0..0xF repeated to 60 nibbles →
  - `fill` saturates at 48;
  - the first `out_valid` follows push 49 with `out_data`=0x0;
  - then 0x1, 0x2, … in order.
- **Back-pressure:** hold `in_valid`=1 continuously → accepts exactly every 10 cycles, no nibble lost or duplicated.
- **Reset mid-sequence:** assert `rst_n`=0 during P2 → `latch`=0 asynchronously, `fill`=0, `out_valid`=0; next push restarts cleanly.
- **Parameter sweep:** PULSE_W=3, GAP_W=2 → period 22 cycles, each pulse 3 cycles wide, ≥2 low cycles between pulses.
- **Flush (`SISO_SEQ_FLUSH_EN`):** push 10 nibbles, assert `flush` → 10 `out_valid` strobes after sequences, `fill`=0, `out_data` equal to pushes 1..10 only once DEPTH pushes have completed (for `fill`<DEPTH, the strobes return the zero-padding first).

Source files
------------

// File: rtl/siso_seq_pkg.sv
// Shared types, default parameters and sequence-length helper for the
// SISO nibble delay-line pulse sequencer.
package siso_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        P0,
        G0,
        P1,
        G1,
        P2,
        G2,
        P3,
        G3
    } seq_state_t;

    typedef logic [3:0] nibble_t;

    localparam int DEF_PULSE_W = 1;
    localparam int DEF_GAP_W   = 1;
    localparam int DEF_DEPTH   = 48;

    // Accept-to-accept period: one IDLE cycle, one SETUP cycle, four pulse+gap pairs.
    function automatic int seq_len(input int pulse_w, input int gap_w);
        return 2 + 4 * (pulse_w + gap_w);
    endfunction

    localparam int SEQ_LEN = seq_len(DEF_PULSE_W, DEF_GAP_W);

endpackage

// File: rtl/siso_seq_if.sv
// Nibble stream interface: push side (valid/ready) and delayed output strobe.
interface siso_seq_if;
    import siso_seq_pkg::*;

    nibble_t in_data;
    logic    in_valid;
    logic    in_ready;
    nibble_t out_data;
    logic    out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/siso_phase_timer.sv
// Loadable down-counter shared by all pulse and gap phases; done while at zero.
module siso_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/siso_pulse_sequencer.sv
// Drives one nibble per handshake into the mux-latch SISO array with four ordered
// latch pulses and samples the nibble leaving it. Optional drain: SISO_SEQ_FLUSH_EN.
module siso_pulse_sequencer
    import siso_seq_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    siso_seq_if.slave                    bus,
`ifdef SISO_SEQ_FLUSH_EN
    input  logic                         flush,
`endif
    output nibble_t                      siso_in,
    input  nibble_t                      siso_out,
    output logic [3:0]                   latch,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);

    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(DEPTH + 1);

    localparam logic [TW-1:0] PW_LD = TW'(PULSE_W - 1);
    localparam logic [TW-1:0] GW_LD = TW'(GAP_W - 1);
    localparam logic [FW-1:0] FULL  = FW'(DEPTH);

    seq_state_t    state;
    logic          tmr_load;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;
    logic          accept;

`ifdef SISO_SEQ_FLUSH_EN
    logic flush_active;
    logic seq_flush;
    logic flush_go;

    // Once started, draining continues on its own until the array is empty.
    assign flush_go     = (flush | flush_active) && (fill != '0);
    assign bus.in_ready = (state == IDLE) && !flush_go;
`else
    assign bus.in_ready = (state == IDLE);
`endif

    assign accept = bus.in_valid & bus.in_ready;

    // Reload on every pulse/gap entry: SETUP and Gk lead into a pulse, Pk into a gap.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = PW_LD;
        case (state)
            SETUP:          tmr_load = 1'b1;
            P0, P1, P2, P3: begin
                tmr_load = tmr_done;
                tmr_val  = GW_LD;
            end
            G0, G1, G2:     tmr_load = tmr_done;
            default:        ;
        endcase
    end

    siso_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            latch         <= '0;
            fill          <= '0;
            siso_in       <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
`ifdef SISO_SEQ_FLUSH_EN
            flush_active  <= 1'b0;
            seq_flush     <= 1'b0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef SISO_SEQ_FLUSH_EN
                    if (flush_go) begin
                        siso_in       <= '0;
                        bus.out_data  <= siso_out;
                        bus.out_valid <= 1'b1;
                        seq_flush     <= 1'b1;
                        flush_active  <= 1'b1;
                        state         <= SETUP;
                    end else
`endif
                    if (accept) begin
                        // siso_out still holds the oldest nibble: the shift has not started.
                        siso_in       <= bus.in_data;
                        bus.out_data  <= siso_out;
                        bus.out_valid <= (fill == FULL);
`ifdef SISO_SEQ_FLUSH_EN
                        seq_flush     <= 1'b0;
`endif
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    state <= P0;
                    latch <= 4'b0001;
                end
                P0: if (tmr_done) begin
                    state <= G0;
                    latch <= '0;
                end
                G0: if (tmr_done) begin
                    state <= P1;
                    latch <= 4'b0010;
                end
                P1: if (tmr_done) begin
                    state <= G1;
                    latch <= '0;
                end
                G1: if (tmr_done) begin
                    state <= P2;
                    latch <= 4'b0100;
                end
                P2: if (tmr_done) begin
                    state <= G2;
                    latch <= '0;
                end
                G2: if (tmr_done) begin
                    state <= P3;
                    latch <= 4'b1000;
                end
                P3: if (tmr_done) begin
                    state <= G3;
                    latch <= '0;
                end
                G3: if (tmr_done) begin
                    state <= IDLE;
`ifdef SISO_SEQ_FLUSH_EN
                    if (seq_flush) begin
                        fill <= fill - 1'b1;
                        if (fill == FW'(1)) flush_active <= 1'b0;
                    end else
`endif
                    if (fill != FULL) fill <= fill + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    latch <= '0;
                end
            endcase
        end
    end

endmodule
